// File: rtl/regm_wport_arb_if.sv
// Bundles the WB, LU, decode-query and register-file write-port signals of regm_wport_arb.
interface regm_wport_arb_if;
  logic        wb_regwrite;
  logic [4:0]  wb_wrreg;
  logic [31:0] wb_wrdata;
  logic        wb_stall;
  logic        lu_valid;
  logic [4:0]  lu_wrreg;
  logic [31:0] lu_wrdata;
  logic        lu_ready;
  logic [4:0]  chk1;
  logic [4:0]  chk2;
  logic        pend1;
  logic        pend2;
  logic        rf_regwrite;
  logic [4:0]  rf_wrreg;
  logic [31:0] rf_wrdata;

  modport master (
    output wb_regwrite, wb_wrreg, wb_wrdata, lu_valid, lu_wrreg, lu_wrdata, chk1, chk2,
    input  wb_stall, lu_ready, pend1, pend2, rf_regwrite, rf_wrreg, rf_wrdata
  );

  modport slave (
    input  wb_regwrite, wb_wrreg, wb_wrdata, lu_valid, lu_wrreg, lu_wrdata, chk1, chk2,
    output wb_stall, lu_ready, pend1, pend2, rf_regwrite, rf_wrreg, rf_wrdata
  );
endinterface

// File: rtl/regm_wport_arb.sv
// Register-file write-port arbiter: WB vs queued long-latency results, with starvation stall.
// Optional same-cycle LU bypass into an idle port when REGM_ARB_BYPASS_EN is defined.
module regm_wport_arb #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic            clk,
  input logic            rst,
  regm_wport_arb_if.slave bus
);
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH-1:0] vld_q, vld_d;
  logic [4:0]            ereg_q [FIFO_DEPTH];
  logic [4:0]            ereg_d [FIFO_DEPTH];
  logic [31:0]           edat_q [FIFO_DEPTH];
  logic [31:0]           edat_d [FIFO_DEPTH];
  logic [SW-1:0]         starve_q, starve_d;
  logic [31:0]           pend_vec;
  logic                  wb_req, fifo_empty, fifo_full, lu_rdy;
  logic                  push, pop, byp;

  assign wb_req     = bus.wb_regwrite && (bus.wb_wrreg != 5'd0);
  assign fifo_empty = ~|vld_q;
  assign fifo_full  = &vld_q;
  assign lu_rdy     = !rst && !fifo_full;
  assign bus.lu_ready = lu_rdy;

  always_comb begin
    rd_ptr_d        = rd_ptr_q;
    wr_ptr_d        = wr_ptr_q;
    vld_d           = vld_q;
    ereg_d          = ereg_q;
    edat_d          = edat_q;
    starve_d        = starve_q;
    bus.rf_regwrite = 1'b0;
    bus.rf_wrreg    = bus.wb_wrreg;
    bus.rf_wrdata   = bus.wb_wrdata;
    bus.wb_stall    = 1'b0;
    pop             = 1'b0;
    byp             = 1'b0;

    if (!rst) begin
      if (fifo_empty) begin
        starve_d = '0;
        if (wb_req) begin
          bus.rf_regwrite = 1'b1;
        end
`ifdef REGM_ARB_BYPASS_EN
        else if (bus.lu_valid && bus.lu_wrreg != 5'd0) begin
          byp             = 1'b1;
          bus.rf_regwrite = 1'b1;
          bus.rf_wrreg    = bus.lu_wrreg;
          bus.rf_wrdata   = bus.lu_wrdata;
        end
`endif
      end else if (!wb_req) begin
        pop = 1'b1;
      end else if (starve_q < SW'(STARVE_MAX)) begin
        bus.rf_regwrite = 1'b1;
        starve_d        = starve_q + SW'(1);
      end else begin
        pop          = 1'b1;
        bus.wb_stall = 1'b1;
      end
    end

    if (pop) begin
      bus.rf_regwrite = 1'b1;
      bus.rf_wrreg    = ereg_q[rd_ptr_q];
      bus.rf_wrdata   = edat_q[rd_ptr_q];
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + PW'(1);
      starve_d        = '0;
    end

    // $zero results are acknowledged but dropped; bypassed results never enter the queue
    push = bus.lu_valid && lu_rdy && (bus.lu_wrreg != 5'd0) && !byp;
    if (push) begin
      ereg_d[wr_ptr_q] = bus.lu_wrreg;
      edat_d[wr_ptr_q] = bus.lu_wrdata;
      vld_d[wr_ptr_q]  = 1'b1;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
  end

  // Pending flags are a scan over live entries, so multiple entries for one register are covered
  always_comb begin
    pend_vec = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (vld_q[i]) pend_vec[ereg_q[i]] = 1'b1;
    end
  end

  assign bus.pend1 = !rst && (bus.chk1 != 5'd0) && pend_vec[bus.chk1];
  assign bus.pend2 = !rst && (bus.chk2 != 5'd0) && pend_vec[bus.chk2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      vld_q    <= '0;
      starve_q <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        ereg_q[i] <= '0;
        edat_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      vld_q    <= vld_d;
      starve_q <= starve_d;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        ereg_q[i] <= ereg_d[i];
        edat_q[i] <= edat_d[i];
      end
    end
  end
endmodule

// File: tb/tb_regm_wport_arb.sv
// Self-checking bench for regm_wport_arb: queue-based reference model plus directed scenarios.
module tb_regm_wport_arb;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned SMAX  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regm_wport_arb_if bus ();

  regm_wport_arb #(.FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];
  int   starve = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  logic        obs_we, obs_stall, obs_rdy, obs_p1, obs_p2;
  logic [4:0]  obs_reg;
  logic [31:0] obs_dat;
  logic        last_stall, last_rdy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic pend_of(input logic [4:0] c);
    if (c == 5'd0) return 1'b0;
    foreach (q[i]) if (q[i].r == c) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: drive at negedge, compare against the model mid-cycle, commit model at posedge
  task automatic step(input logic r, input logic wbw, input logic [4:0] wbr, input logic [31:0] wbd,
                      input logic luv, input logic [4:0] lur, input logic [31:0] lud,
                      input logic [4:0] c1, input logic [4:0] c2);
    logic wreq, e_we, e_stall, e_rdy, e_p1, e_p2, do_pop, do_push, byp;
    logic [4:0]  e_reg;
    logic [31:0] e_dat;
    @(negedge clk);
    rst = r;
    bus.wb_regwrite = wbw; bus.wb_wrreg = wbr; bus.wb_wrdata = wbd;
    bus.lu_valid = luv; bus.lu_wrreg = lur; bus.lu_wrdata = lud;
    bus.chk1 = c1; bus.chk2 = c2;
    #1;
    wreq = wbw && (wbr != 5'd0);
    e_we = 1'b0; e_stall = 1'b0; do_pop = 1'b0; byp = 1'b0;
    e_reg = wbr; e_dat = wbd;
    if (r) begin
      e_rdy = 1'b0; e_p1 = 1'b0; e_p2 = 1'b0;
    end else begin
      e_rdy = (q.size() < DEPTH);
      e_p1 = pend_of(c1);
      e_p2 = pend_of(c2);
      if (q.size() == 0) begin
        e_we = wreq;
`ifdef REGM_ARB_BYPASS_EN
        if (!wreq && luv && lur != 5'd0) begin
          byp = 1'b1; e_we = 1'b1; e_reg = lur; e_dat = lud;
        end
`endif
      end else if (!wreq || starve == SMAX) begin
        do_pop = 1'b1; e_stall = wreq;
      end else begin
        e_we = 1'b1;
      end
      if (do_pop) begin
        e_we = 1'b1; e_reg = q[0].r; e_dat = q[0].d;
      end
    end
    do_push = !r && luv && e_rdy && (lur != 5'd0) && !byp;

    obs_we = bus.rf_regwrite; obs_reg = bus.rf_wrreg; obs_dat = bus.rf_wrdata;
    obs_stall = bus.wb_stall; obs_rdy = bus.lu_ready;
    obs_p1 = bus.pend1; obs_p2 = bus.pend2;
    chk("rf_regwrite", 32'(obs_we), 32'(e_we));
    chk("wb_stall", 32'(obs_stall), 32'(e_stall));
    chk("lu_ready", 32'(obs_rdy), 32'(e_rdy));
    chk("pend1", 32'(obs_p1), 32'(e_p1));
    chk("pend2", 32'(obs_p2), 32'(e_p2));
    if (e_we) begin
      chk("rf_wrreg", 32'(obs_reg), 32'(e_reg));
      chk("rf_wrdata", obs_dat, e_dat);
    end
    last_stall = e_stall;
    last_rdy = e_rdy;

    @(posedge clk);
    cyc++;
    if (r) begin
      q.delete(); starve = 0;
    end else begin
      if (do_pop) begin
        void'(q.pop_front()); starve = 0;
      end else if (q.size() != 0 && wreq) begin
        starve++;
      end
      if (do_push) q.push_back('{r: lur, d: lud});
      if (q.size() == 0) starve = 0;
    end
  endtask

  task automatic idle(input int n, input logic [4:0] c1);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, c1, 0);
  endtask

  logic        rw, rwbw, rluv;
  logic [4:0]  rwbr, rlur, rc1, rc2;
  logic [31:0] rwbd, rlud;

  initial begin
    bus.wb_regwrite = 0; bus.wb_wrreg = 0; bus.wb_wrdata = 0;
    bus.lu_valid = 0; bus.lu_wrreg = 0; bus.lu_wrdata = 0;
    bus.chk1 = 0; bus.chk2 = 0;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 5, 32'h55, 1, 6, 32'h66, 6, 0);
    chk("lit_rst_we", 32'(obs_we), 0);
    chk("lit_rst_rdy", 32'(obs_rdy), 0);
    idle(1, 0);
    chk("lit_reset_rdy", 32'(obs_rdy), 1);

    // Scenario 2: idle WB, single LU push to r8
    step(0, 0, 0, 0, 1, 8, 32'h11, 8, 0);
`ifdef REGM_ARB_BYPASS_EN
    chk("t2_byp_we", 32'(obs_we), 1);
    chk("t2_byp_reg", 32'(obs_reg), 8);
    idle(1, 8);
    chk("t2_byp_pend", 32'(obs_p1), 0);
`else
    chk("t2_we0", 32'(obs_we), 0);
    idle(1, 8);
    chk("t2_we", 32'(obs_we), 1);
    chk("t2_reg", 32'(obs_reg), 8);
    chk("t2_dat", obs_dat, 32'h11);
    chk("t2_pend_hi", 32'(obs_p1), 1);
    idle(1, 8);
    chk("t2_pend_lo", 32'(obs_p1), 0);
`endif
    idle(2, 0);

    // Scenario 3: WB every cycle, one LU push of r9
    for (int k = 0; k < 7; k++) begin
      step(0, 1, 3, 32'h300 + k, k == 0, 9, 32'h99, 9, 0);
      if (k >= 1 && k <= 4) chk("t3_wb_grant", 32'(obs_stall), 0);
      if (k == 4) chk("t3_reg4", 32'(obs_reg), 3);
      if (k == 5) begin
        chk("t3_stall", 32'(obs_stall), 1);
        chk("t3_reg5", 32'(obs_reg), 9);
        chk("t3_pend5", 32'(obs_p1), 1);
      end
      if (k == 6) begin
        chk("t3_stall6", 32'(obs_stall), 0);
        chk("t3_reg6", 32'(obs_reg), 3);
        chk("t3_pend6", 32'(obs_p1), 0);
      end
    end
    idle(2, 0);

    // Scenario 4: fill the queue while WB is busy; third result waits for a pop
    for (int k = 0; k < 7; k++) begin
      step(0, 1, 5, 32'h500 + k, 1, (k == 0) ? 5'd1 : (k == 1) ? 5'd2 : 5'd3, 32'hA00 + k, 3, 0);
      if (k == 2) chk("t4_full", 32'(obs_rdy), 0);
      if (k == 5) begin
        chk("t4_full5", 32'(obs_rdy), 0);
        chk("t4_pop_reg", 32'(obs_reg), 1);
      end
      if (k == 6) begin
        chk("t4_rdy6", 32'(obs_rdy), 1);
        chk("t4_p3_pre", 32'(obs_p1), 0);
      end
    end
    idle(1, 3);
    chk("t4_p3_post", 32'(obs_p1), 1);
    idle(3, 0);

    // Scenario 5: both sides target $zero
    step(0, 1, 0, 32'hDEAD, 1, 0, 32'hBEEF, 0, 0);
    chk("t5_we", 32'(obs_we), 0);
    idle(1, 0);
    chk("t5_we_next", 32'(obs_we), 0);
    chk("t5_rdy", 32'(obs_rdy), 1);

    // Scenario 6: two results for r10 drain in order
    step(0, 1, 4, 32'h40, 1, 10, 32'hA, 10, 0);
    step(0, 1, 4, 32'h41, 1, 10, 32'hB, 10, 0);
    chk("t6_pend1", 32'(obs_p1), 1);
    idle(1, 10);
    chk("t6_datA", obs_dat, 32'hA);
    chk("t6_pendA", 32'(obs_p1), 1);
    idle(1, 10);
    chk("t6_datB", obs_dat, 32'hB);
    chk("t6_pendB", 32'(obs_p1), 1);
    idle(1, 10);
    chk("t6_pend_clr", 32'(obs_p1), 0);

    // Scenario 1: reset while two entries are queued
    step(0, 1, 5, 32'h50, 1, 6, 32'h6, 0, 0);
    step(0, 1, 5, 32'h51, 1, 7, 32'h7, 0, 0);
    step(1, 1, 5, 32'h52, 0, 0, 0, 6, 7);
    chk("t1_rst_we", 32'(obs_we), 0);
    chk("t1_rst_rdy", 32'(obs_rdy), 0);
    step(0, 0, 0, 0, 0, 0, 0, 6, 7);
    chk("t1_we", 32'(obs_we), 0);
    chk("t1_rdy", 32'(obs_rdy), 1);
    chk("t1_p1", 32'(obs_p1), 0);
    chk("t1_p2", 32'(obs_p2), 0);

    // Randomized traffic honouring the hold rules for stalled WB and unaccepted LU
    rwbw = 0; rwbr = 0; rwbd = 0; rluv = 0; rlur = 0; rlud = 0;
    last_stall = 0; last_rdy = 1;
    for (int n = 0; n < 3000; n++) begin
      rw = ($urandom_range(0, 199) == 0);
      if (!last_stall) begin
        rwbw = ($urandom_range(0, 99) < 65);
        rwbr = 5'($urandom_range(0, 7));
        rwbd = $urandom;
      end
      if (!(rluv && !last_rdy)) begin
        rluv = ($urandom_range(0, 99) < 40);
        rlur = 5'($urandom_range(0, 7));
        rlud = $urandom;
      end
      rc1 = 5'($urandom_range(0, 7));
      rc2 = 5'($urandom_range(0, 7));
      step(rw, rwbw, rwbr, rwbd, rluv, rlur, rlud, rc1, rc2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
